// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared state encoding and frame width for spi_slave
package spi_slave_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - N-stage synchronizer with history flop and edge strobes
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder; SPI_SLAVE_OVERRUN_EN adds the sticky overrun flag
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] IDLE_BYTE   = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_write,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_read,
  output logic                busy,
  output logic                overrun
);

  logic sck_rise, sck_fall, unused_sck_level;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .d     (sck),
    .level (unused_sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .d     (cs_n),
    .level (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .d     (mosi),
    .level (mosi_s),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic                reload;
  logic [SPI_BITS-1:0] rx_shift;
  logic [SPI_BITS-1:0] tx_shift;
  logic [SPI_BITS-1:0] tx_buf;
  logic [SPI_BITS-1:0] next_tx;
  logic                tx_copy;

  // The first sck fall after a completed byte loads the next TX byte instead of shifting.
  assign tx_copy = ((state == IDLE) && cs_fall) ||
                   ((state == SHIFT) && !cs_rise && sck_fall && reload);
  assign next_tx = tx_ready ? IDLE_BYTE : tx_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      reload   <= 1'b0;
      rx_shift <= '0;
      tx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      miso_oe  <= ~cs_s;
      busy     <= ~cs_s;
      miso     <= ~cs_s & tx_shift[SPI_BITS-1];
      case (state)
        IDLE: begin
          if (cs_fall) begin
            tx_shift <= next_tx;
            bit_cnt  <= '0;
            reload   <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            bit_cnt <= '0;
            reload  <= 1'b0;
            state   <= IDLE;
          end else begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[SPI_BITS-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(SPI_BITS - 1)) state <= DONE;
            end
            if (sck_fall) begin
              if (reload) begin
                tx_shift <= next_tx;
                reload   <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
          reload   <= ~cs_rise;
          bit_cnt  <= '0;
          state    <= cs_rise ? IDLE : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write coinciding with a copy refills the buffer the copy just drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else if (tx_write && (tx_ready || tx_copy)) begin
      tx_buf   <= tx_data;
      tx_ready <= 1'b0;
    end else if (tx_copy) begin
      tx_ready <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_full;
  logic done_now;

  assign done_now = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_full <= done_now | (rx_full & ~rx_read);
      overrun <= (done_now & rx_full & ~rx_read) | (overrun & ~rx_read);
    end
  end
`else
  logic unused_rx_read;

  assign unused_rx_read = rx_read;
  assign overrun        = 1'b0;
`endif

endmodule
